// File: rtl/wishbone_manager_pkg.sv
// rtl/wishbone_manager_pkg.sv - shared Wishbone manager types and defaults
package wishbone_manager_pkg;

  localparam int          WB_ADDR_W   = 32;
  localparam int          WB_DATA_W   = 32;
  localparam logic [31:0] WB_ERR_DATA = 32'hBAD0_BAD0;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BUS  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating ACK wait counter with expiry flag
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int              LAST     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  logic [CNT_W-1:0] r_count;

  // Parks on the last value instead of wrapping; a zero limit never counts.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (TIMEOUT_CYCLES != 0) && (r_count != LAST_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && (r_count == LAST_CNT);

endmodule

// File: rtl/wishbone_manager.sv
// rtl/wishbone_manager.sv - single-beat request to Wishbone B4 classic cycle bridge
module wishbone_manager
  import wishbone_manager_pkg::*;
#(
  parameter int                ADDR_W         = WB_ADDR_W,
  parameter int                DATA_W         = WB_DATA_W,
  parameter int                SEL_W          = DATA_W / 8,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = WB_ERR_DATA
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] adr_to_mem,
  input  logic [DATA_W-1:0] data_to_mem,
  input  logic [SEL_W-1:0]  sel_to_mem,
  output logic [DATA_W-1:0] data_from_mem,
  output logic              mem_busy,
  output logic              mem_timeout,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [SEL_W-1:0]  SEL_O,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              ACK_I
);

  wb_state_t         r_state;
  logic              r_cyc;
  logic              r_we;
  logic              r_busy;
  logic              r_timeout;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_rdata;
  logic              w_expired;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .nRst      (nRst),
    .i_clear   (r_state == WB_IDLE),
    .i_enable  ((r_state == WB_BUS) && !ACK_I),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= WB_IDLE;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (mem_read || mem_write) begin
            r_adr   <= adr_to_mem;
            r_dat   <= data_to_mem;
            r_sel   <= sel_to_mem;
            r_we    <= mem_write;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= WB_BUS;
          end
        end
        WB_BUS: begin
          // ACK takes priority over an expiry landing on the same edge.
          if (ACK_I) begin
            if (!r_we) r_rdata <= DAT_I;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= WB_IDLE;
          end else if (w_expired) begin
            if (!r_we) r_rdata <= ERR_DATA;
            r_timeout <= 1'b1;
            r_cyc     <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= WB_IDLE;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

  assign CYC_O         = r_cyc;
  assign STB_O         = r_cyc;
  assign WE_O          = r_we;
  assign ADR_O         = r_adr;
  assign DAT_O         = r_dat;
  assign SEL_O         = r_sel;
  assign data_from_mem = r_rdata;
  assign mem_busy      = r_busy;
  assign mem_timeout   = r_timeout;

endmodule

// File: tb/tb_wishbone_manager.sv
// tb/tb_wishbone_manager.sv - directed and randomized bench for wishbone_manager
module tb_wishbone_manager;

  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr_to_mem = '0;
  logic [31:0] data_to_mem = '0;
  logic [3:0]  sel_to_mem = '0;
  logic [31:0] data_from_mem;
  logic        mem_busy;
  logic        mem_timeout;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I = '0;
  logic        ACK_I = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_data = '0;
  logic [31:0] exp_adr  = '0;
  logic [31:0] exp_dat  = '0;
  logic [3:0]  exp_sel  = '0;
  logic        exp_we   = 1'b0;

  wishbone_manager #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .sel_to_mem    (sel_to_mem),
    .data_from_mem (data_from_mem),
    .mem_busy      (mem_busy),
    .mem_timeout   (mem_timeout),
    .CYC_O         (CYC_O),
    .STB_O         (STB_O),
    .WE_O          (WE_O),
    .ADR_O         (ADR_O),
    .DAT_O         (DAT_O),
    .SEL_O         (SEL_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"},   CYC_O, 0);
    chk({tag, "_stb"},   STB_O, 0);
    chk({tag, "_busy"},  mem_busy, 0);
    chk({tag, "_to"},    mem_timeout, 0);
    chk({tag, "_we"},    WE_O, 0);
    chk({tag, "_adr"},   ADR_O, 0);
    chk({tag, "_dat"},   DAT_O, 0);
    chk({tag, "_sel"},   SEL_O, 0);
    chk({tag, "_rdata"}, data_from_mem, 0);
  endtask

  // Present a request at the current negedge; check the bus one edge later.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    mem_read    = rd;
    mem_write   = wr;
    adr_to_mem  = adr;
    data_to_mem = dat;
    sel_to_mem  = sel;
    @(negedge clk);
    exp_adr = adr;
    exp_dat = dat;
    exp_sel = sel;
    exp_we  = wr;
    chk("req_cyc",   CYC_O, 1);
    chk("req_stb",   STB_O, 1);
    chk("req_busy",  mem_busy, 1);
    chk("req_to",    mem_timeout, 0);
    chk("req_we",    WE_O, exp_we);
    chk("req_adr",   ADR_O, exp_adr);
    chk("req_dat",   DAT_O, exp_dat);
    chk("req_sel",   SEL_O, exp_sel);
    chk("req_rdata", data_from_mem, exp_data);
  endtask

  // Slave waits d bus cycles before ACK (NEVER = no ACK at all).
  task automatic run_bus(input int d, input logic [31:0] ackdat, input logic distract);
    int end_c;
    int to_cnt;
    int exp_end;
    logic exp_to;
    end_c  = 0;
    to_cnt = 0;
    mem_read   = distract;
    mem_write  = 1'b0;
    adr_to_mem = distract ? 32'h1000 : $urandom;
    for (int c = 1; c <= 50; c++) begin
      ACK_I = (c == d + 1);
      DAT_I = (c == d + 1) ? ackdat : $urandom;
      @(negedge clk);
      ACK_I = 1'b0;
      if (mem_timeout) to_cnt++;
      if (!mem_busy) begin
        end_c = c;
        break;
      end
      chk("bus_hold_adr", ADR_O, exp_adr);
      chk("bus_hold_cyc", CYC_O, 1);
    end
    exp_end = (d < T) ? d + 1 : T;
    exp_to  = (d >= T);
    if (!exp_we) exp_data = exp_to ? ERR : ackdat;
    chk("busy_cycles", end_c, exp_end);
    chk("timeout_pulses", to_cnt, exp_to);
    chk("end_cyc", CYC_O, 0);
    chk("end_stb", STB_O, 0);
    chk("end_rdata", data_from_mem, exp_data);
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      ACK_I = 1'($urandom_range(0, 1));
      DAT_I = $urandom;
      @(negedge clk);
      chk("idle_cyc",   CYC_O, 0);
      chk("idle_busy",  mem_busy, 0);
      chk("idle_to",    mem_timeout, 0);
      chk("idle_adr",   ADR_O, exp_adr);
      chk("idle_we",    WE_O, exp_we);
      chk("idle_rdata", data_from_mem, exp_data);
    end
    ACK_I = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    nRst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    issue(1'b1, 1'b0, 32'hABCDE, 32'h0, 4'b1111);
    run_bus(2, 32'hABCDE101, 1'b0);
    idle(1);

    issue(1'b0, 1'b1, 32'hFAB1, 32'h1234_5678, 4'b0011);
    run_bus(1, 32'h5555_AAAA, 1'b0);
    idle(2);

    issue(1'b1, 1'b0, 32'hCAB1, 32'h0, 4'b1111);
    run_bus(NEVER, 32'h0, 1'b0);

    issue(1'b1, 1'b0, 32'h2000, 32'h0, 4'b1111);
    run_bus(3, 32'h2000_0001, 1'b1);
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'b1111);
    run_bus(T - 1, 32'hFACE_0001, 1'b0);
    idle(1);

    issue(1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0101);
    run_bus(0, 32'h0BAD_0000, 1'b0);
    idle(1);

    for (int k = 0; k < 30; k++) begin
      logic rd, wr;
      int   d;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      d  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, T + 2));
      issue(rd, wr, $urandom, $urandom, 4'($urandom));
      run_bus(d, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(1);
    issue(1'b1, 1'b0, 32'h4444, 32'h0, 4'b1111);
    mem_read = 1'b0;
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("async_cyc",  CYC_O, 0);
    chk("async_stb",  STB_O, 0);
    chk("async_busy", mem_busy, 0);
    chk("async_to",   mem_timeout, 0);
    @(negedge clk);
    nRst = 1'b1;
    exp_data = '0;
    exp_adr  = '0;
    exp_dat  = '0;
    exp_sel  = '0;
    exp_we   = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");

    issue(1'b1, 1'b0, 32'h5000, 32'h0, 4'b1000);
    run_bus(4, 32'h1357_9BDF, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
